// File: rtl/bsa_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package bsa_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } bsa_state_e;

  // Bit-index counter width; never below one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/half_adder_cell.sv
// Single half-adder cell; two of these make the serial full adder.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: LSB-first, one bit per enabled cycle, start/busy/done handshake.
// Optional subtract mode via `define SUBTRACT_EN (adds the sub input).
module bit_serial_adder_ctrl
  import bsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  bsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, done_q;

  logic b_bit, s1, c1, s_bit, c2, carry_new;

`ifdef SUBTRACT_EN
  logic sub_q, sub_d;
  // Subtraction is a + ~b + 1: invert b bits, seed carry with sub.
  assign b_bit = b_sr_q[0] ^ sub_q;
`else
  assign b_bit = b_sr_q[0];
`endif

  half_adder_cell u_ha0 (
    .a (a_sr_q[0]),
    .b (b_bit),
    .s (s1),
    .c (c1)
  );

  half_adder_cell u_ha1 (
    .a (s1),
    .b (carry_q),
    .s (s_bit),
    .c (c2)
  );

  assign carry_new = c1 | c2;

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SUBTRACT_EN
    sub_d   = sub_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sr_d  = op_a;
          b_sr_d  = op_b;
          s_sr_d  = '0;
          cnt_d   = '0;
`ifdef SUBTRACT_EN
          sub_d   = sub;
          carry_d = sub;
`else
          carry_d = 1'b0;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d = carry_new;
        s_sr_d  = {s_bit, s_sr_q[WIDTH-1:1]};
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {s_bit, s_sr_q[WIDTH-1:1]};
          cout_d  = carry_new;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; ena low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else if (ena) begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
`ifdef SUBTRACT_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/bit_serial_adder_ctrl.md
Name: bit_serial_adder_ctrl

Overview:
Sequencer that reuses one half-adder datapath, as two half-adder cells forming a full adder, to add two WIDTH-bit operands one bit per cycle.
- LSB first, carry held in a flop.
- Start/busy/done handshake toward the top-level tt_um wrapper, which maps operands from ui_in/uio_in and the result to uo_out.
- Trades latency for area in the tile.

Parameters:
WIDTH, 8, operand and result width in bits (>=2)

Ports:
clk     in   1      clock
rst_n   in   1      reset, asynchronous, active-low
ena     in   1      clock enable; low freezes all state
start   in   1      request; sampled only in IDLE with ena=1
op_a    in   WIDTH  operand A; captured on accepted start
op_b    in   WIDTH  operand B; captured on accepted start
busy    out  1      high in RUN and DONE
done    out  1      high for exactly one enabled cycle, in DONE
sum     out  WIDTH  result register
cout    out  1      carry out of MSB (result register)

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift regs/carry/count=0.
- States: IDLE, RUN, DONE. Registered FSM; busy/done decoded from state.
- IDLE + ena + start:
  - latch op_a/op_b into shift regs a_sr/b_sr
  - carry=0, cnt=0, go RUN
- RUN, each ena cycle:
  - s = a_sr[0]^b_sr[0]^carry via two half-adder cells
  - carry = c1|c2
  - s shifted into MSB of s_sr; a_sr/b_sr shift right; cnt++
- RUN when cnt==WIDTH-1:
  - final bit processed
  - sum <= {s, s_sr[WIDTH-1:1]}, cout <= new carry
  - go DONE
- DONE: done=1; next ena cycle -> IDLE.
- Latency: accepted start at edge E0; sum/cout update and done rises at edge E(WIDTH); done falls at E(WIDTH+1). For WIDTH=8, 9 cycles start-to-idle.
- sum/cout change only on entering DONE. They hold the last result through IDLE and the whole of the next operation.
- start in RUN/DONE is ignored. No queueing. A start held high in DONE is not accepted until IDLE.
- ena=0: state, counters, shift regs and outputs frozen. done stays high if frozen in DONE.
- rst_n low mid-operation: immediate return to reset values, operation discarded, no done.
- Arithmetic is modulo 2^WIDTH; overflow reported only via cout.

Optional Feature:
SUBTRACT_EN
- Defined:
  - adds input port sub (1 bit), captured with operands
  - sub=1: b bits inverted into datapath, initial carry=1
  - result = op_a - op_b mod 2^WIDTH; cout=1 means no borrow (op_a>=op_b)
  - sub=0: plain add
- Undefined: port absent, add only, initial carry always 0.

Decomposition:
- Package bsa_pkg holds:
  - state enum typedef (IDLE/RUN/DONE, 2-bit)
  - function for counter width, clog2(WIDTH)
  - localparam encodings
- Sub-module half_adder_cell: inputs a, b; outputs s=a^b, c=a&b; purely combinational. Instantiated twice to form the full adder.
- FSM, counter and shift registers stay in the top.

Test Plan:
- Reset, then start with op_a=100, op_b=55, ena=1:
  - busy high from next cycle
  - done pulses 1 cycle, 8 cycles after start edge
  - sum=155, cout=0; busy low one cycle later
- op_a=255, op_b=1 -> sum=0, cout=1. Previous sum (155) held unchanged throughout RUN.
- start re-asserted with op_a=3, op_b=3 during RUN of 10+20:
  - result 30, single done pulse
  - second start ignored; no second operation
- rst_n pulsed low during RUN (cycle 4) of 200+100:
  - busy/done/sum/cout=0 immediately
  - IDLE after release; no done
  - new 1+1 -> sum=2
- ena toggled 1/0 every cycle during 77+88 -> sum=165, cout=0; done after 16 clock edges.
- SUBTRACT_EN builds:
  - sub=1, 5-7 -> sum=254, cout=0
  - sub=1, 7-5 -> sum=2, cout=1
  - sub=0, 7+5 -> sum=12
